// File: rtl/conv_frame_controller.sv
// Frame sequencer for a KxK convolution core: line buffers, window assembly, coefficient bank,
// latency-matched valid/coordinate tag pipe and non-negative output clamp.
module conv_frame_controller #(
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned IMG_WIDTH    = 640,
  parameter int unsigned IMG_HEIGHT   = 480,
  parameter int unsigned CORE_LATENCY = 2
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic                                                   start,
  input  logic                                                   kcoef_we,
  input  logic [$clog2(KERNEL_SIZE)-1:0]                         kcoef_row,
  input  logic [$clog2(KERNEL_SIZE)-1:0]                         kcoef_col,
  input  logic [WORD_SIZE-1:0]                                   kcoef_data,
  input  logic                                                   in_valid,
  input  logic [WORD_SIZE-1:0]                                   in_pixel,
  output logic                                                   in_ready,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] win_out,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] kernel_out,
  input  logic [WORD_SIZE-1:0]                                   core_ans,
  output logic                                                   out_valid,
  output logic [WORD_SIZE-1:0]                                   out_pixel,
  output logic [$clog2(IMG_WIDTH)-1:0]                           out_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]                          out_y,
  output logic                                                   busy,
  output logic                                                   frame_done
);

  localparam int unsigned K    = KERNEL_SIZE;
  localparam int unsigned XW   = $clog2(IMG_WIDTH);
  localparam int unsigned YW   = $clog2(IMG_HEIGHT);
  localparam int unsigned HALF = (K - 1) / 2;
  localparam int unsigned L    = CORE_LATENCY;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                                 state_q, state_d;
  logic                                   accept, last_px, tag_in;
  logic [XW-1:0]                          x_q;
  logic [YW-1:0]                          y_q;
  logic [K-1:0][K-1:0][WORD_SIZE-1:0]     win_q, kernel_q;
  logic [WORD_SIZE-1:0]                   lb_q [K-1][IMG_WIDTH];
  logic [WORD_SIZE-1:0]                   col [K];
  logic [L:0]                             tag_v_q, tag_last_q;
  logic [XW-1:0]                          tag_x_q [L+1];
  logic [YW-1:0]                          tag_y_q [L+1];

  assign in_ready   = (state_q == StRun);
  assign busy       = (state_q != StIdle);
  assign accept     = in_valid && in_ready;
  assign last_px    = (x_q == XW'(IMG_WIDTH - 1)) && (y_q == YW'(IMG_HEIGHT - 1));
  // Only fully populated windows of the current frame produce results.
  assign tag_in     = accept && (x_q >= XW'(K - 1)) && (y_q >= YW'(K - 1));
  assign win_out    = win_q;
  assign kernel_out = kernel_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accept && last_px) state_d = StDrain;
      StDrain: if (tag_last_q[L]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // New window column: line buffers (oldest row first) topped by the incoming pixel.
  always_comb begin
    for (int r = 0; r < int'(K) - 1; r++) col[r] = lb_q[r][x_q];
    col[K-1] = in_pixel;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start) begin
        x_q <= '0;
        y_q <= '0;
      end else if (accept) begin
        if (x_q == XW'(IMG_WIDTH - 1)) begin
          x_q <= '0;
          y_q <= (y_q == YW'(IMG_HEIGHT - 1)) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q    <= '0;
      kernel_q <= '0;
    end else begin
      if (accept) begin
        for (int r = 0; r < int'(K); r++) begin
          for (int c = 0; c < int'(K) - 1; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][K-1] <= col[r];
        end
      end
      if (state_q == StIdle && kcoef_we) kernel_q[kcoef_row][kcoef_col] <= kcoef_data;
    end
  end

  // Line-buffer RAM carries no reset; stale rows are masked by the y >= K-1 validity rule.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < int'(K) - 2; r++) lb_q[r][x_q] <= lb_q[r+1][x_q];
      lb_q[K-2][x_q] <= in_pixel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v_q    <= '0;
      tag_last_q <= '0;
      for (int i = 0; i <= int'(L); i++) begin
        tag_x_q[i] <= '0;
        tag_y_q[i] <= '0;
      end
    end else begin
      tag_v_q    <= {tag_v_q[L-1:0], tag_in};
      tag_last_q <= {tag_last_q[L-1:0], accept && last_px};
      for (int i = int'(L); i > 0; i--) begin
        tag_x_q[i] <= tag_x_q[i-1];
        tag_y_q[i] <= tag_y_q[i-1];
      end
      tag_x_q[0] <= x_q - XW'(HALF);
      tag_y_q[0] <= y_q - YW'(HALF);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_pixel  <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else begin
      out_valid  <= tag_v_q[L];
      frame_done <= tag_last_q[L];
      if (tag_v_q[L]) begin
        out_pixel <= core_ans[WORD_SIZE-1] ? '0 : core_ans;
        out_x     <= tag_x_q[L];
        out_y     <= tag_y_q[L];
      end
    end
  end

endmodule

// File: tb/tb_conv_frame_controller.sv
// Directed bench for conv_frame_controller on a 4x4 frame with a 3x3 kernel and a 2-stage core model.
module tb_conv_frame_controller;
  localparam int K = 3, WS = 16, W = 4, H = 4, L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         reset_n, start, kcoef_we, in_valid, in_ready;
  logic [1:0]                   kcoef_row, kcoef_col;
  logic [WS-1:0]                kcoef_data, in_pixel, core_ans, out_pixel;
  logic [K-1:0][K-1:0][WS-1:0]  win_out, kernel_out;
  logic                         out_valid, busy, frame_done;
  logic [1:0]                   out_x, out_y;

  conv_frame_controller #(
    .KERNEL_SIZE(K), .WORD_SIZE(WS), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CORE_LATENCY(L)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .kcoef_we(kcoef_we),
    .kcoef_row(kcoef_row), .kcoef_col(kcoef_col), .kcoef_data(kcoef_data),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .win_out(win_out), .kernel_out(kernel_out), .core_ans(core_ans),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_x(out_x), .out_y(out_y),
    .busy(busy), .frame_done(frame_done)
  );

  // Core model: dot product of window and kernel, two register stages, wraps to WS bits.
  int                  conv_sum;
  logic signed [WS-1:0] s1, s2;
  always_comb begin
    conv_sum = 0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        conv_sum += int'($signed(win_out[r][c])) * int'($signed(kernel_out[r][c]));
  end
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= conv_sum[WS-1:0];
      s2 <= s1;
    end
  end
  assign core_ans = s2;

  int n_cmp = 0, n_bad = 0, cyc = 0, fd_n = 0;
  logic [WS-1:0] ov_pix[$];
  int            ov_x[$], ov_y[$], ov_cyc[$], acc_cyc[$];
  bit            ov_fd[$], ov_busy[$];
  int            exp_idx[4] = '{10, 11, 14, 15};

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid) begin
      ov_pix.push_back(out_pixel);
      ov_x.push_back(int'(out_x));
      ov_y.push_back(int'(out_y));
      ov_cyc.push_back(cyc);
      ov_fd.push_back(frame_done);
      ov_busy.push_back(busy);
    end
    if (frame_done) fd_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic clear_log();
    ov_pix.delete(); ov_x.delete(); ov_y.delete(); ov_cyc.delete();
    ov_fd.delete(); ov_busy.delete(); acc_cyc.delete();
  endtask

  task automatic write_coef(input int r, input int c, input logic [WS-1:0] v);
    @(negedge clk);
    kcoef_we = 1'b1; kcoef_row = 2'(r); kcoef_col = 2'(c); kcoef_data = v;
    @(negedge clk);
    kcoef_we = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // konst < 0 sends pixel value = raster index; gaps inserts one idle cycle after each pixel.
  task automatic feed(input int n, input bit gaps, input int konst);
    for (int i = 0; i < n; i++) begin
      int g = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_pixel = (konst < 0) ? WS'(i) : WS'(konst);
      while (!in_ready && g < 20) begin @(negedge clk); g++; end
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL feed_ready px%0d: got %b expected 1", i, in_ready);
      end
      acc_cyc.push_back(cyc + 1);
      if (gaps) begin @(negedge clk); in_valid = 1'b0; end
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_done(input int fd0);
    int g = 0;
    while (fd_n == fd0 && g < 40) begin @(negedge clk); g++; end
    @(negedge clk);
    n_cmp++;
    if (fd_n !== fd0 + 1) begin
      n_bad++; $display("FAIL frame_done_count: got %0d expected %0d", fd_n - fd0, 1);
    end
  endtask

  task automatic test_reset();
    n_cmp += 7;
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b expected 0", frame_done); end
    if (out_pixel !== '0)   begin n_bad++; $display("FAIL rst_out_pixel: got %0d expected 0", out_pixel); end
    if (win_out !== '0)     begin n_bad++; $display("FAIL rst_win_out: got %h expected 0", win_out); end
    if (kernel_out !== '0)  begin n_bad++; $display("FAIL rst_kernel_out: got %h expected 0", kernel_out); end
  endtask

  task automatic test_identity();
    int vals[4] = '{5, 6, 9, 10};
    int fd0;
    write_coef(1, 1, 16'd1);
    clear_log(); fd0 = fd_n;
    start_frame(); feed(16, 1'b0, -1); wait_done(fd0);
    n_cmp++;
    if (ov_pix.size() !== 4) begin
      n_bad++; $display("FAIL id_count: got %0d expected 4", ov_pix.size());
    end
    for (int j = 0; j < ov_pix.size() && j < 4; j++) begin
      n_cmp += 5;
      if (ov_pix[j] !== WS'(vals[j])) begin n_bad++; $display("FAIL id_pix%0d: got %0d expected %0d", j, ov_pix[j], vals[j]); end
      if (ov_x[j] !== exp_idx[j] % W - 1) begin n_bad++; $display("FAIL id_x%0d: got %0d expected %0d", j, ov_x[j], exp_idx[j] % W - 1); end
      if (ov_y[j] !== exp_idx[j] / W - 1) begin n_bad++; $display("FAIL id_y%0d: got %0d expected %0d", j, ov_y[j], exp_idx[j] / W - 1); end
      if (ov_cyc[j] !== acc_cyc[exp_idx[j]] + 3) begin n_bad++; $display("FAIL id_lat%0d: got %0d expected %0d", j, ov_cyc[j], acc_cyc[exp_idx[j]] + 3); end
      if (ov_fd[j] !== (j == 3)) begin n_bad++; $display("FAIL id_fd%0d: got %b expected %b", j, ov_fd[j], j == 3); end
    end
    n_cmp += 5;
    if (ov_busy.size() > 2 && ov_busy[2] !== 1'b1) begin n_bad++; $display("FAIL id_busy_drain: got 0 expected 1"); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL id_busy_after: got %b expected 0", busy); end
    if (win_out[2][2] !== 16'd15) begin n_bad++; $display("FAIL id_win22: got %0d expected 15", win_out[2][2]); end
    if (win_out[1][2] !== 16'd11) begin n_bad++; $display("FAIL id_win12: got %0d expected 11", win_out[1][2]); end
    if (win_out[0][0] !== 16'd5)  begin n_bad++; $display("FAIL id_win00: got %0d expected 5", win_out[0][0]); end
  endtask

  task automatic test_gaps();
    int vals[4] = '{5, 6, 9, 10};
    int fd0;
    clear_log(); fd0 = fd_n;
    start_frame(); feed(16, 1'b1, -1); wait_done(fd0);
    n_cmp++;
    if (ov_pix.size() !== 4) begin n_bad++; $display("FAIL gap_count: got %0d expected 4", ov_pix.size()); end
    for (int j = 0; j < ov_pix.size() && j < 4; j++) begin
      n_cmp += 4;
      if (ov_pix[j] !== WS'(vals[j])) begin n_bad++; $display("FAIL gap_pix%0d: got %0d expected %0d", j, ov_pix[j], vals[j]); end
      if (ov_x[j] !== exp_idx[j] % W - 1) begin n_bad++; $display("FAIL gap_x%0d: got %0d expected %0d", j, ov_x[j], exp_idx[j] % W - 1); end
      if (ov_y[j] !== exp_idx[j] / W - 1) begin n_bad++; $display("FAIL gap_y%0d: got %0d expected %0d", j, ov_y[j], exp_idx[j] / W - 1); end
      if (ov_cyc[j] !== acc_cyc[exp_idx[j]] + 3) begin n_bad++; $display("FAIL gap_lat%0d: got %0d expected %0d", j, ov_cyc[j], acc_cyc[exp_idx[j]] + 3); end
    end
  endtask

  task automatic test_clamp();
    int fd0;
    for (int pass = 0; pass < 2; pass++) begin
      logic [WS-1:0] coef, expv;
      coef = (pass == 0) ? 16'hFFFF : 16'd2;
      expv = (pass == 0) ? 16'd0 : 16'd10;
      write_coef(1, 1, coef);
      clear_log(); fd0 = fd_n;
      start_frame(); feed(16, 1'b0, 5); wait_done(fd0);
      n_cmp++;
      if (ov_pix.size() !== 4) begin n_bad++; $display("FAIL clamp%0d_count: got %0d expected 4", pass, ov_pix.size()); end
      for (int j = 0; j < ov_pix.size(); j++) begin
        n_cmp++;
        if (ov_pix[j] !== expv) begin n_bad++; $display("FAIL clamp%0d_pix%0d: got %0d expected %0d", pass, j, ov_pix[j], expv); end
      end
    end
  endtask

  task automatic test_midrun_writes();
    int vals[4] = '{5, 6, 9, 10};
    int fd0;
    write_coef(1, 1, 16'd1);
    clear_log(); fd0 = fd_n;
    start_frame();
    fork
      feed(16, 1'b0, -1);
      begin
        repeat (5) @(negedge clk);
        kcoef_we = 1'b1; kcoef_row = 2'd0; kcoef_col = 2'd0; kcoef_data = 16'd7; start = 1'b1;
        @(negedge clk);
        kcoef_we = 1'b0; start = 1'b0;
        n_cmp += 2;
        if (kernel_out[0][0] !== 16'd0) begin n_bad++; $display("FAIL mid_kernel00: got %0d expected 0", kernel_out[0][0]); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b expected 1", busy); end
      end
    join
    wait_done(fd0);
    n_cmp++;
    if (ov_pix.size() !== 4) begin n_bad++; $display("FAIL mid_count: got %0d expected 4", ov_pix.size()); end
    for (int j = 0; j < ov_pix.size() && j < 4; j++) begin
      n_cmp++;
      if (ov_pix[j] !== WS'(vals[j])) begin n_bad++; $display("FAIL mid_pix%0d: got %0d expected %0d", j, ov_pix[j], vals[j]); end
    end
    write_coef(2, 2, 16'd3);
    n_cmp += 2;
    if (kernel_out[2][2] !== 16'd3) begin n_bad++; $display("FAIL idle_kernel22: got %0d expected 3", kernel_out[2][2]); end
    if (kernel_out[1][1] !== 16'd1) begin n_bad++; $display("FAIL idle_kernel11: got %0d expected 1", kernel_out[1][1]); end
  endtask

  task automatic test_reset_abort();
    int vals[4] = '{5, 6, 9, 10};
    int fd0;
    clear_log(); fd0 = fd_n;
    start_frame(); feed(7, 1'b0, -1);
    reset_n = 1'b0;
    #1;
    n_cmp += 6;
    if (busy !== 1'b0)      begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL abort_in_ready: got %b expected 0", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    if (out_pixel !== '0)   begin n_bad++; $display("FAIL abort_out_pixel: got %0d expected 0", out_pixel); end
    if (win_out !== '0)     begin n_bad++; $display("FAIL abort_win_out: got %h expected 0", win_out); end
    if (kernel_out !== '0)  begin n_bad++; $display("FAIL abort_kernel_out: got %h expected 0", kernel_out); end
    @(negedge clk); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (fd_n !== fd0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected %0d", fd_n, fd0); end
    write_coef(1, 1, 16'd1);
    clear_log(); fd0 = fd_n;
    start_frame(); feed(16, 1'b0, -1); wait_done(fd0);
    n_cmp++;
    if (ov_pix.size() !== 4) begin n_bad++; $display("FAIL rerun_count: got %0d expected 4", ov_pix.size()); end
    for (int j = 0; j < ov_pix.size() && j < 4; j++) begin
      n_cmp += 4;
      if (ov_pix[j] !== WS'(vals[j])) begin n_bad++; $display("FAIL rerun_pix%0d: got %0d expected %0d", j, ov_pix[j], vals[j]); end
      if (ov_x[j] !== exp_idx[j] % W - 1) begin n_bad++; $display("FAIL rerun_x%0d: got %0d expected %0d", j, ov_x[j], exp_idx[j] % W - 1); end
      if (ov_y[j] !== exp_idx[j] / W - 1) begin n_bad++; $display("FAIL rerun_y%0d: got %0d expected %0d", j, ov_y[j], exp_idx[j] / W - 1); end
      if (ov_cyc[j] !== acc_cyc[exp_idx[j]] + 3) begin n_bad++; $display("FAIL rerun_lat%0d: got %0d expected %0d", j, ov_cyc[j], acc_cyc[exp_idx[j]] + 3); end
    end
  endtask

  initial begin
    reset_n = 1'b1; start = 1'b0; kcoef_we = 1'b0; kcoef_row = '0; kcoef_col = '0;
    kcoef_data = '0; in_valid = 1'b0; in_pixel = '0;
    #1 reset_n = 1'b0;
    #2 test_reset();
    @(negedge clk); reset_n = 1'b1;
    test_identity();
    test_gaps();
    test_clamp();
    test_midrun_writes();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
